// File: rtl/ddr_wr_sender.sv
`default_nettype none
// ============================================================================
// Module   : ddr_wr_sender
// Brief    : Packs an 8-bit gray pixel stream six pixels per 64-bit word,
//            buffers the words in a small FIFO and writes them to the DDR
//            controller in fixed-length bursts (req/ack + valid/ready).
//            The last word of every zone segment is tagged with wr_end.
// Options  : WR_TAG_EN - when defined, wr_data[63:48] carries
//            {seg_idx, word index[6:0]} sampled at push; otherwise zero.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_wr_sender #(
  parameter int WORDS_PER_SEG = 477,
  parameter int SEGS          = 360,
  parameter int BURST_LEN     = 8,
  parameter int FIFO_DEPTH    = 16,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_x1,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          frame_end,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          wr_req,
  input  logic          wr_ack,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [63:0]   wr_data,
  output logic          wr_end,
  output logic [8:0]    seg_idx,
  output logic [CW-1:0] fifo_cnt,
  output logic          ovf_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BL_W    = CW'(BURST_LEN);
  localparam logic [CW-1:0] DEPTH_W = CW'(FIFO_DEPTH);
  localparam logic [8:0]    WPS_W   = 9'(WORDS_PER_SEG);
  localparam logic [8:0]    SEGS_W  = 9'(SEGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [2:0]    pix_cnt, pix_cnt_n;
  logic [47:0]   pack_buf, pack_buf_n;
  logic          pend_push, pend_push_n;
  logic [8:0]    word_cnt;      // words already pushed in the current segment
  logic [8:0]    word_idx;      // 1-based index of the word being pushed
  logic          seg_last;
  logic          flush;
  logic          push, pop, fifo_wr, fifo_full;
  logic [47:0]   push_word;
  logic [15:0]   tag;
  logic [64:0]   fifo_mem [FIFO_DEPTH];
  logic [64:0]   head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] blen, blen_n, bcnt, bcnt_n;

  // Packer next state: place pixels MSB-first, complete a word on the 6th
  // pixel, and arm a zero-filled partial push when frame_end leaves a residue.
  always_comb begin
    pix_cnt_n   = pix_cnt;
    pack_buf_n  = pack_buf;
    pend_push_n = pend_push;
    if (frame_start) begin
      pix_cnt_n   = 3'd0;
      pack_buf_n  = 48'h0;
      pend_push_n = 1'b0;
    end else begin
      if (pend_push) begin
        pix_cnt_n   = 3'd0;
        pack_buf_n  = 48'h0;
        pend_push_n = 1'b0;
      end
      if (pix_valid) begin
        if (pix_cnt_n == 3'd5) begin
          pix_cnt_n  = 3'd0;
          pack_buf_n = 48'h0;
        end else begin
          for (int k = 0; k < 5; k++) begin
            if (pix_cnt_n == 3'(k)) pack_buf_n[47-8*k -: 8] = pix_data;
          end
          pix_cnt_n = pix_cnt_n + 3'd1;
        end
      end
      if (frame_end && pix_cnt_n != 3'd0) pend_push_n = 1'b1;
    end
  end

  assign push      = !frame_start &&
                     (pend_push || (pix_valid && pix_cnt == 3'd5));
  assign push_word = pend_push ? pack_buf : {pack_buf[47:8], pix_data};
  assign word_idx  = word_cnt + 9'd1;
  assign seg_last  = (word_idx == WPS_W);

`ifdef WR_TAG_EN
  assign tag = {seg_idx, word_idx[6:0]};
`else
  assign tag = 16'h0;
`endif

  // Packer registers.
  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt   <= 3'd0;
      pack_buf  <= 48'h0;
      pend_push <= 1'b0;
    end else begin
      pix_cnt   <= pix_cnt_n;
      pack_buf  <= pack_buf_n;
      pend_push <= pend_push_n;
    end
  end

  // Segment/frame counters advance on every push, dropped or not, so the
  // segment boundaries stay aligned after an overflow.
  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= 9'd0;
      seg_idx  <= 9'd1;
    end else if (frame_start) begin
      word_cnt <= 9'd0;
      seg_idx  <= 9'd1;
    end else if (push) begin
      if (seg_last) begin
        word_cnt <= 9'd0;
        seg_idx  <= (seg_idx == SEGS_W) ? 9'd1 : seg_idx + 9'd1;
      end else begin
        word_cnt <= word_idx;
      end
    end
  end

  // FIFO control; a push into a full FIFO succeeds only if a pop frees a slot.
  assign fifo_full = (fifo_cnt == DEPTH_W);
  assign pop       = (state == BURST) && wr_ready && (fifo_cnt != '0);
  assign fifo_wr   = push && (!fifo_full || pop);
  assign head      = fifo_mem[rptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_nx = fifo_cnt;
    if (fifo_wr && !pop)      cnt_nx = fifo_cnt + CW'(1);
    else if (!fifo_wr && pop) cnt_nx = fifo_cnt - CW'(1);
  end

  // FIFO storage (data only, no reset needed).
  always_ff @(posedge clk_x1) begin
    if (fifo_wr) fifo_mem[wptr] <= {seg_last, tag, push_word};
  end

  // FIFO pointers, occupancy, sticky overflow and the flush flag.
  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      ovf_err  <= 1'b0;
      flush    <= 1'b0;
    end else begin
      if (fifo_wr) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      fifo_cnt <= cnt_nx;
      if (frame_start)                ovf_err <= 1'b0;
      else if (push && fifo_full && !pop) ovf_err <= 1'b1;
      if (frame_start)    flush <= 1'b0;
      else if (frame_end) flush <= 1'b1;
      else if (flush && !pend_push && cnt_nx == '0) flush <= 1'b0;
    end
  end

  // Burst FSM next state; IDLE looks at the post-push occupancy so a full
  // burst is requested the cycle right after the word that completes it.
  always_comb begin
    state_n = state;
    blen_n  = blen;
    bcnt_n  = bcnt;
    case (state)
      IDLE: begin
        if (cnt_nx >= BL_W || (flush && cnt_nx != '0)) begin
          state_n = REQ;
          blen_n  = (cnt_nx >= BL_W) ? BL_W : cnt_nx;
          bcnt_n  = '0;
        end
      end
      REQ: begin
        if (wr_ack) state_n = BURST;
      end
      BURST: begin
        if (pop) begin
          bcnt_n = bcnt + CW'(1);
          if (bcnt + CW'(1) == blen) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Burst FSM registers.
  always_ff @(posedge clk_x1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      blen  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      blen  <= blen_n;
      bcnt  <= bcnt_n;
    end
  end

  // Head of FIFO is presented directly (fall-through) and held while stalled.
  assign wr_req   = (state == REQ);
  assign wr_valid = (state == BURST);
  assign wr_data  = wr_valid ? head[63:0] : 64'h0;
  assign wr_end   = wr_valid & head[64];

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_wr_sender
// Brief    : Directed self-checking bench for ddr_wr_sender, built with small
//            segment/frame sizes so full segments and the frame wrap fit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_wr_sender;

  localparam int WPS   = 10;
  localparam int NSEG  = 4;
  localparam int BL    = 8;
  localparam int DEPTH = 16;

  logic        clk_x1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h0;
  logic        wr_req, wr_ack = 1'b0, wr_valid, wr_ready = 1'b1, wr_end, ovf_err;
  logic [63:0] wr_data;
  logic [8:0]  seg_idx;
  logic [4:0]  fifo_cnt;

  ddr_wr_sender #(
    .WORDS_PER_SEG(WPS), .SEGS(NSEG), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_x1(clk_x1), .rst_n(rst_n), .frame_start(frame_start),
    .frame_end(frame_end), .pix_valid(pix_valid), .pix_data(pix_data),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_end(wr_end),
    .seg_idx(seg_idx), .fifo_cnt(fifo_cnt), .ovf_err(ovf_err)
  );

  always #5 clk_x1 = ~clk_x1;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } vec_t;

  vec_t        vecs[8];
  int          n_cmp = 0, n_fail = 0;
  logic [64:0] got[$];
  int          blens[32];
  int          nb = 0;
  bit          ack_en = 1'b1, toggle = 1'b0, req_prev = 1'b0;
  bit          held_v = 1'b0;
  logic [64:0] held_d;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Six consecutive pixel values starting at p0, packed MSB-first.
  function automatic logic [63:0] pw(input int p0);
    logic [63:0] w;
    w = 64'h0;
    for (int i = 0; i < 6; i++) w[47-8*i -: 8] = 8'(p0 + i);
    return w;
  endfunction

  // Controller model: ack one cycle after wr_req is first seen, ready either
  // constantly high or toggling every cycle.
  always @(posedge clk_x1) begin
    #1;
    if (!rst_n) begin
      wr_ack   = 1'b0;
      req_prev = 1'b0;
    end else begin
      if (wr_ack) wr_ack = 1'b0;
      else if (ack_en && wr_req && req_prev) wr_ack = 1'b1;
      req_prev = wr_req;
      wr_ready = toggle ? ~wr_ready : 1'b1;
    end
  end

  // Word/burst logger plus the hold-while-stalled check.
  always @(negedge clk_x1) begin
    if (rst_n) begin
      if (held_v && wr_valid) chk("hold during stall", {wr_end, wr_data}, held_d);
      held_v = wr_valid && !wr_ready;
      held_d = {wr_end, wr_data};
      if (wr_ack && wr_req) nb++;
      if (wr_valid && wr_ready) begin
        got.push_back({wr_end, wr_data});
        if (nb > 0) blens[nb-1]++;
      end
    end
  end

  task automatic clear_log();
    got.delete();
    nb = 0;
    for (int i = 0; i < 32; i++) blens[i] = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk_x1); #1 frame_start = 1'b1;
    @(posedge clk_x1); #1 frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    @(posedge clk_x1); #1 frame_end = 1'b1;
    @(posedge clk_x1); #1 frame_end = 1'b0;
  endtask

  task automatic send_pix(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_x1); #1 pix_valid = 1'b1; pix_data = 8'(first + i);
    end
    @(posedge clk_x1); #1 pix_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int n);
    int t;
    t = 0;
    while (got.size() < n && t < 3000) begin
      @(negedge clk_x1);
      t++;
    end
    repeat (20) @(negedge clk_x1);
    chk(name, 65'(got.size()), 65'(n));
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (got.size() > i) begin
        chk($sformatf("%s vec%0d data", tag, i), {1'b0, got[i][63:0]}, {1'b0, vecs[i].data});
        chk($sformatf("%s vec%0d end", tag, i), 65'(got[i][64]), 65'(vecs[i].last));
      end else begin
        chk($sformatf("%s vec%0d missing", tag, i), 65'(got.size()), 65'(i + 1));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ends;
    vecs[0] = '{64'h0000_0102_0304_0506, 1'b0};
    vecs[1] = '{64'h0000_0708_090A_0B0C, 1'b0};
    vecs[2] = '{64'h0000_0D0E_0F10_1112, 1'b0};
    vecs[3] = '{64'h0000_1314_1516_1718, 1'b0};
    vecs[4] = '{64'h0000_191A_1B1C_1D1E, 1'b0};
    vecs[5] = '{64'h0000_1F20_2122_2324, 1'b0};
    vecs[6] = '{64'h0000_2526_2728_292A, 1'b0};
    vecs[7] = '{64'h0000_2B2C_2D2E_2F30, 1'b0};

    // Reset state
    repeat (3) @(negedge clk_x1);
    chk("reset wr_req/valid/end/ovf", {61'h0, wr_req, wr_valid, wr_end, ovf_err}, 65'h0);
    chk("reset wr_data", {1'b0, wr_data}, 65'h0);
    chk("reset seg_idx", 65'(seg_idx), 65'd1);
    chk("reset fifo_cnt", 65'(fifo_cnt), 65'd0);
    @(posedge clk_x1); #1 rst_n = 1'b1;

    // 48 pixels -> one 8-word burst
    clear_log();
    pulse_start();
    send_pix(1, 48);
    drain("basic word count", 8);
    check_table("basic");
    chk("basic burst count", 65'(nb), 65'd1);
    chk("basic burst len", 65'(blens[0]), 65'd8);

    // 50 pixels + frame_end -> 9 words, bursts 8 then 1
    clear_log();
    pulse_start();
    send_pix(1, 50);
    pulse_end();
    drain("flush word count", 9);
    check_table("flush");
    if (got.size() > 8) chk("flush partial word", got[8], {1'b0, 64'h0000_3132_0000_0000});
    chk("flush burst count", 65'(nb), 65'd2);
    chk("flush burst0 len", 65'(blens[0]), 65'd8);
    chk("flush burst1 len", 65'(blens[1]), 65'd1);
    chk("flush fifo empty", 65'(fifo_cnt), 65'd0);

    // Backpressure: ready toggles during the burst
    toggle = 1'b1;
    clear_log();
    pulse_start();
    send_pix(1, 48);
    drain("stall word count", 8);
    check_table("stall");
    toggle = 1'b0;

    // Full segments and frame wrap
    clear_log();
    pulse_start();
    send_pix(1, WPS * 6);
    chk("seg_idx after seg1", 65'(seg_idx), 65'd2);
    send_pix(WPS * 6 + 1, (NSEG - 1) * WPS * 6);
    chk("seg_idx after wrap", 65'(seg_idx), 65'd1);
    drain("wrap word count", NSEG * WPS);
    ends = 0;
    for (int j = 0; j < got.size(); j++) begin
      if (got[j][64]) ends++;
      if (j % WPS == WPS - 1) chk($sformatf("wrap end at word %0d", j), 65'(got[j][64]), 65'd1);
    end
    chk("wrap end count", 65'(ends), 65'(NSEG));
    if (got.size() > 39) chk("wrap word39 data", {1'b0, got[39][63:0]}, {1'b0, pw(235)});
    chk("wrap burst count", 65'(nb), 65'd5);

    // Overflow: no acks while 17 words arrive
    ack_en = 1'b0;
    clear_log();
    pulse_start();
    send_pix(1, 17 * 6);
    @(negedge clk_x1);
    chk("ovf fifo_cnt", 65'(fifo_cnt), 65'd16);
    chk("ovf ovf_err", 65'(ovf_err), 65'd1);
    chk("ovf wr_req", 65'(wr_req), 65'd1);
    pulse_start();
    @(negedge clk_x1);
    chk("ovf cleared by frame_start", 65'(ovf_err), 65'd0);
    chk("ovf fifo kept", 65'(fifo_cnt), 65'd16);
    ack_en = 1'b1;
    drain("ovf word count", 16);
    if (got.size() > 15) begin
      chk("ovf word0", {1'b0, got[0][63:0]}, {1'b0, pw(1)});
      chk("ovf word9 end", 65'(got[9][64]), 65'd1);
      chk("ovf word10 data", got[10], {1'b0, pw(61)});
      chk("ovf word15", {1'b0, got[15][63:0]}, {1'b0, pw(91)});
    end
    chk("ovf burst count", 65'(nb), 65'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
